// File: rtl/instruction_loader.sv
// Boot loader: assembles framed little-endian bytes into 32-bit program-memory writes, checks a trailing sum, then releases the core.
// Accepts one byte per cycle while loading (Byte_Ready_o low only in DONE/ERROR); write strobe lands one cycle after lane 3.
module instruction_loader #(
    parameter int PROGRAM_MEMORY_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Byte_i,
    input  logic        Byte_Valid_i,
    output logic        Byte_Ready_o,
    output logic        Mem_Write_o,
    output logic [31:0] Mem_Address_o,
    output logic [31:0] Mem_Data_o,
    output logic        Core_Run_o,
    output logic        Done_o,
    output logic        Error_o
);

    localparam logic [15:0] MAX_WORDS = 16'(PROGRAM_MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  sum_q, sum_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        accept;
    logic [15:0] n_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_HDR_LO;
            n_q         <= '0;
            word_cnt_q  <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            sum_q       <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        lane_d       = lane_q;
        word_d       = word_q;
        sum_d        = sum_q;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        Byte_Ready_o = 1'b0;
        n_full       = {Byte_i, n_q[7:0]};

        case (state_q)
            S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM: Byte_Ready_o = 1'b1;
            default:                            Byte_Ready_o = 1'b0;
        endcase

        accept = Byte_Valid_i && Byte_Ready_o;

        if (accept) begin
            case (state_q)
                S_HDR_LO: begin
                    n_d[7:0] = Byte_i;
                    sum_d    = sum_q + Byte_i;
                    state_d  = S_HDR_HI;
                end
                S_HDR_HI: begin
                    n_d   = n_full;
                    sum_d = sum_q + Byte_i;
                    if (n_full > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (n_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    word_d[{lane_q, 3'b000} +: 8] = Byte_i;
                    sum_d  = sum_q + Byte_i;
                    lane_d = lane_q + 2'd1;
                    // Lane 3 completes the word; the assembled value bypasses word_q.
                    if (lane_q == 2'd3) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {14'd0, word_cnt_q, 2'b00};
                        mem_data_d  = {Byte_i, word_q[23:0]};
                        word_cnt_d  = word_cnt_q + 16'd1;
                        if (word_cnt_d == n_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    state_d = (Byte_i == sum_q) ? S_DONE : S_ERROR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign Mem_Write_o   = mem_write_q;
    assign Mem_Address_o = mem_addr_q;
    assign Mem_Data_o    = mem_data_q;
    assign Done_o        = (state_q == S_DONE);
    assign Core_Run_o    = (state_q == S_DONE);
    assign Error_o       = (state_q == S_ERROR);

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core's program memory. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It issues one write per word into program memory and verifies a trailing checksum. It holds the core stopped until the image is loaded and verified, then releases it.

## Interface
- PROGRAM_MEMORY_DEPTH, 64, program memory capacity in 32-bit words; maximum accepted word count.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- Byte_i  input  8  incoming stream byte.
- Byte_Valid_i  input  1  Byte_i holds a valid byte.
- Byte_Ready_o  output  1  loader can accept a byte this cycle.
- Mem_Write_o  output  1  one-cycle write strobe to program memory.
- Mem_Address_o  output  32  byte address of the word being written (word-aligned, 4*k).
- Mem_Data_o  output  32  instruction word being written.
- Core_Run_o  output  1  1 = core may run; 0 = hold core in reset.
- Done_o  output  1  image loaded and checksum matched.
- Error_o  output  1  oversize image or checksum mismatch.

## Operation
- Frame: HDR_LO byte, HDR_HI byte (16-bit word count N, little-endian), then 4*N data bytes, then 1 checksum byte.
- Transfer: a byte is accepted on a rising edge where Byte_Valid_i && Byte_Ready_o. Byte_Ready_o is combinational from state: 1 in S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM; 0 in S_DONE, S_ERROR. Byte_Valid_i may toggle freely. Unaccepted bytes are ignored.
- States and transitions:
  - S_HDR_LO -> S_HDR_HI on accept; captures N[7:0].
  - S_HDR_HI -> on accept, capture N[15:8], then:
    - N > PROGRAM_MEMORY_DEPTH -> S_ERROR.
    - N == 0 -> S_CSUM.
    - otherwise -> S_DATA.
  - S_DATA: 2-bit byte lane counter. The byte with lane index i goes to word bits [8i+7:8i], so the first byte lands in [7:0]. On acceptance of lane 3, the word is complete; the word counter k increments. When k reaches N, go to S_CSUM.
  - S_CSUM -> S_DONE if the accepted byte equals the running sum, else S_ERROR.
  - S_DONE, S_ERROR: terminal until reset.
- Checksum: 8-bit running sum, mod 256, of every accepted byte before the checksum byte (header and data). Cleared on reset.
- Write: for word k, Mem_Address_o = 4*k and Mem_Data_o = the assembled word. Word counter is 16 bits wide; address is zero-extended to 32 bits.
- Core_Run_o = 1 only in S_DONE. Done_o = (state == S_DONE). Error_o = (state == S_ERROR).
- Memory writes already issued are not undone on error; the core simply stays held.

## Timing
- Reset values (registered outputs): Mem_Write_o=0, Mem_Address_o=0, Mem_Data_o=0, Core_Run_o=0, Done_o=0, Error_o=0. State S_HDR_LO, so Byte_Ready_o=1 in the first cycle after reset.
- Mem_Write_o, Mem_Address_o and Mem_Data_o are registered. The strobe is high for exactly one cycle, in the cycle after lane 3 is accepted. Address and data are held stable until the next write.
- Back-to-back bytes are accepted at one per cycle with no bubbles, including across word boundaries and into S_CSUM.
- Done_o, Error_o and Core_Run_o go high in the cycle after the checksum byte, or HDR_HI byte for oversize, is accepted.
- Reset mid-frame: returns to S_HDR_LO next cycle. The partial word, counters and checksum are discarded. A pending Mem_Write_o is forced to 0.
- Reset from S_DONE drops Core_Run_o to 0 in the next cycle.
- N == PROGRAM_MEMORY_DEPTH is legal. The last write address is 4*(DEPTH-1) = 252 at default.

## Test plan
- Single word: stream 01,00,13,05,A0,00,B9 (sum 0x01+0x13+0x05+0xA0 = 0xB9) -> one Mem_Write_o pulse with address 0 and data 0x00A00513; Done_o=1 and Core_Run_o=1 next cycle; Byte_Ready_o=0 afterwards.
- Two words with Byte_Valid_i toggling every other cycle -> writes at address 0 then 4 with correct little-endian data; no duplicate or dropped bytes; Done_o=1.
- Bad checksum: same frame as the single-word case with trailer 0xBA -> one write occurs, Error_o=1, Core_Run_o stays 0, Done_o=0.
- Oversize: header 41,00 (N=65) at default depth -> Error_o=1 the cycle after HDR_HI is accepted; no Mem_Write_o; Byte_Ready_o=0.
- Empty image: 00,00,00 -> no writes; Done_o=1.
- Reset mid-word: assert reset after 2 data bytes, then send the valid single-word frame -> all outputs 0 during reset; exactly one write, address 0, data 0x00A00513; Done_o=1.
